// File: rtl/jzjpcc_uart_pkg.sv
// Shared types and register field positions for the JZJ MMIO UART blocks.
// The transmitter uses them now; a future receiver can reuse the same package.
package jzjpcc_uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  localparam int BYTE_WIDTH  = 8;

  // Command word fields
  localparam int DATA_LSB    = 0;
  localparam int TOGGLE_BIT  = 8;
  localparam int ENABLE_BIT  = 31;

  // Status word fields
  localparam int ACK_BIT     = 8;
  localparam int FULL_BIT    = 9;
  localparam int EMPTY_BIT   = 10;
  localparam int BUSY_BIT    = 11;
  localparam int COUNT_LSB   = 16;
  localparam int COUNT_WIDTH = 8;

endpackage

// File: rtl/jzjpcc_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// popData always presents the head entry; a push is also accepted when full if a pop happens on the same edge.
module jzjpcc_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      pushData,
  input  logic                  pop,
  output logic [WIDTH-1:0]      popData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(1) << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic                  doPush;
  logic                  doPop;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is intentionally not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/jzjpcc_mmio_uart_tx.sv
// MMIO-attached 8N1 UART transmitter: toggle-handshake command word in, status word out,
// bytes buffered in a FIFO and shifted out LSB first on uartTx.
module jzjpcc_mmio_uart_tx
  import jzjpcc_uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] txCommand,
  output logic [31:0] txStatus,
  output logic        uartTx
);

  localparam int                       COUNTER_WIDTH = $clog2(CLOCKS_PER_BIT);
  localparam logic [COUNTER_WIDTH-1:0] BIT_RELOAD    = COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);

  txState_t                  state;
  txState_t                  nextState;
  logic [COUNTER_WIDTH-1:0]  counter;
  logic [2:0]                bitIndex;
  logic [BYTE_WIDTH-1:0]     shiftReg;
  logic                      ackToggle;
  logic                      busy;
  logic                      startFrame;
  logic                      canStart;
  logic                      counterZero;
  logic                      txEnable;
  logic                      requestPending;
  logic                      fifoPush;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic [FIFO_DEPTH_LOG2:0]  fifoCount;
  logic [BYTE_WIDTH-1:0]     fifoHead;
  logic                      unusedCommandBits;

  assign unusedCommandBits = ^txCommand[30:9];
  assign txEnable          = txCommand[ENABLE_BIT];
  assign requestPending    = txCommand[TOGGLE_BIT] != ackToggle;
  assign counterZero       = (counter == '0);
  assign canStart          = !fifoEmpty && txEnable;

  // A full FIFO still takes the pending byte on the edge that pops the head, so a
  // stalled writer resumes on the very first frame start.
  assign fifoPush = requestPending && (!fifoFull || startFrame);

  jzjpcc_sync_fifo #(
    .WIDTH      (BYTE_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifoPush),
    .pushData (txCommand[DATA_LSB +: BYTE_WIDTH]),
    .pop      (startFrame),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ackToggle <= 1'b0;
    else if (fifoPush) ackToggle <= txCommand[TOGGLE_BIT];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    nextState  = state;
    startFrame = 1'b0;
    case (state)
      IDLE: begin
        if (canStart) begin
          startFrame = 1'b1;
          nextState  = START;
        end
      end
      START: if (counterZero) nextState = DATA;
      DATA:  if (counterZero && bitIndex == 3'd7) nextState = STOP;
      STOP: begin
        if (counterZero) begin
          if (canStart) begin
            startFrame = 1'b1;
            nextState  = START;
          end else begin
            nextState  = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Serial datapath: the line level is registered so it changes only on bit boundaries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uartTx   <= 1'b1;
      counter  <= '0;
      bitIndex <= '0;
      shiftReg <= '0;
    end else if (startFrame) begin
      shiftReg <= fifoHead;
      uartTx   <= 1'b0;
      counter  <= BIT_RELOAD;
    end else if (state != IDLE) begin
      if (!counterZero) begin
        counter <= counter - 1'b1;
      end else begin
        counter <= BIT_RELOAD;
        case (state)
          START: begin
            uartTx   <= shiftReg[0];
            bitIndex <= '0;
          end
          DATA: begin
            if (bitIndex == 3'd7) begin
              uartTx <= 1'b1;
            end else begin
              shiftReg <= shiftReg >> 1;
              uartTx   <= shiftReg[1];
              bitIndex <= bitIndex + 1'b1;
            end
          end
          STOP:    uartTx <= 1'b1;
          default: uartTx <= 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    busy                                 = (state != IDLE);
    txStatus                             = '0;
    txStatus[ACK_BIT]                    = ackToggle;
    txStatus[FULL_BIT]                   = fifoFull;
    txStatus[EMPTY_BIT]                  = fifoEmpty;
    txStatus[BUSY_BIT]                   = busy;
    txStatus[COUNT_LSB +: COUNT_WIDTH]   = COUNT_WIDTH'(fifoCount);
  end

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Directed/randomized bench for jzjpcc_mmio_uart_tx: software-side toggle protocol driver,
// serial line decoder, and an expected-byte queue compared against what the line carried.
module tb_jzjpcc_mmio_uart_tx;

  localparam int CPB   = 4;
  localparam int FDL2  = 3;
  localparam int FRAME = CPB * 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] txCommand = '0;
  logic [31:0] txStatus;
  logic        uartTx;

  jzjpcc_mmio_uart_tx #(
    .CLOCKS_PER_BIT  (CPB),
    .FIFO_DEPTH_LOG2 (FDL2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .txCommand (txCommand),
    .txStatus  (txStatus),
    .uartTx    (uartTx)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic        tgl = 1'b0;
  logic        en  = 1'b0;
  logic [7:0]  expQ[$];
  logic [7:0]  rxQ[$];
  int          startQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mkStatus(input logic ack, input logic full, input logic empty,
                                           input logic busy, input int count);
    logic [31:0] s;
    s        = '0;
    s[8]     = ack;
    s[9]     = full;
    s[10]    = empty;
    s[11]    = busy;
    s[23:16] = count[7:0];
    return s;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  // Software write: flip the toggle, random junk in the ignored bits.
  task automatic writeCmd(input logic [7:0] b);
    logic [31:0] c;
    tgl   = ~tgl;
    c     = $urandom;
    c[7:0] = b;
    c[8]  = tgl;
    c[31] = en;
    txCommand = c;
    expQ.push_back(b);
  endtask

  task automatic setEnable(input logic e);
    en            = e;
    txCommand[31] = e;
  endtask

  task automatic waitAck(input string tag);
    for (int i = 0; i < 20 && txStatus[8] !== tgl; i++) tick();
    check(tag, {31'b0, txStatus[8]}, {31'b0, tgl});
  endtask

  task automatic drainCompare(input string tag);
    int target;
    target = expQ.size();
    for (int i = 0; i < target * FRAME + 200 && rxQ.size() < target; i++) tick();
    repeat (2 * FRAME) tick();
    check({tag, "_rx_count"}, rxQ.size(), target);
    while (rxQ.size() > 0 && expQ.size() > 0)
      check({tag, "_rx_byte"}, {24'b0, rxQ.pop_front()}, {24'b0, expQ.pop_front()});
    expQ.delete();
    rxQ.delete();
  endtask

  // Line decoder: finds a falling start edge, samples mid-bit, checks framing.
  int         cyc = 0;
  logic       inFrame = 1'b0;
  int         phase = 0;
  int         rxStart = 0;
  logic [7:0] rxByte = '0;

  always @(negedge clock) begin
    int k;
    cyc++;
    if (reset !== 1'b1) begin
      inFrame = 1'b0;
    end else begin
      if (!inFrame && uartTx === 1'b0) begin
        inFrame = 1'b1;
        phase   = 0;
        rxStart = cyc;
      end else if (inFrame) begin
        phase++;
      end
      if (inFrame && (phase % CPB) == CPB / 2) begin
        k = phase / CPB;
        if (k == 0) begin
          check("rx_start_bit", {31'b0, uartTx}, 32'd0);
        end else if (k <= 8) begin
          rxByte[k-1] = uartTx;
        end else begin
          check("rx_stop_bit", {31'b0, uartTx}, 32'd1);
          rxQ.push_back(rxByte);
          startQ.push_back(rxStart);
          inFrame = 1'b0;
        end
      end
    end
  end

  initial begin
    #(1_000_000);
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [9:0] frameBits;
    int         lowSeen;

    // 1: reset and idle
    #1 reset = 1'b0;
    txCommand = '0;
    repeat (3) tick();
    check("t1_status_in_reset", txStatus, 32'h00000400);
    check("t1_line_in_reset", {31'b0, uartTx}, 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("t1_idle_status", txStatus, 32'h00000400);
      check("t1_idle_line", {31'b0, uartTx}, 32'd1);
    end

    // 2: single frame timing
    en  = 1'b1;
    tgl = 1'b1;
    txCommand = 32'h80000155;
    expQ.push_back(8'h55);
    tick();
    check("t2_ack_after_push", txStatus, mkStatus(1'b1, 1'b0, 1'b0, 1'b0, 1));
    check("t2_line_still_idle", {31'b0, uartTx}, 32'd1);
    tick();
    check("t2_status_start", txStatus, mkStatus(1'b1, 1'b0, 1'b1, 1'b1, 0));
    frameBits = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < FRAME + 4; c++) begin
      if (c > 0) tick();
      check("t2_line", {31'b0, uartTx}, (c < FRAME) ? {31'b0, frameBits[c / CPB]} : 32'd1);
      check("t2_busy", {31'b0, txStatus[11]}, (c < FRAME) ? 32'd1 : 32'd0);
    end
    drainCompare("t2");

    // 3: fill with transmit disabled, stalled ninth write, back-to-back drain
    setEnable(1'b0);
    for (int i = 1; i <= 8; i++) begin
      writeCmd(8'(i));
      waitAck("t3_fill_ack");
    end
    check("t3_full_status", txStatus, mkStatus(tgl, 1'b1, 1'b0, 1'b0, 8));
    b = 8'($urandom);
    writeCmd(b);
    repeat (5) tick();
    check("t3_stalled_status", txStatus, mkStatus(~tgl, 1'b1, 1'b0, 1'b0, 8));
    startQ.delete();
    setEnable(1'b1);
    tick();
    check("t3_accept_on_pop", txStatus, mkStatus(tgl, 1'b1, 1'b0, 1'b1, 8));
    check("t3_line_start", {31'b0, uartTx}, 32'd0);
    drainCompare("t3");
    check("t3_frame_count", startQ.size(), 9);
    for (int i = 0; i + 1 < startQ.size(); i++)
      check("t3_frame_gap", startQ[i+1] - startQ[i], FRAME);

    // 4: mismatch held for many cycles pushes once
    writeCmd(8'($urandom));
    repeat (20) tick();
    check("t4_ack", {31'b0, txStatus[8]}, {31'b0, tgl});
    drainCompare("t4");

    // 5: reset mid-frame
    writeCmd($urandom & 8'hF7);
    waitAck("t5_ack1");
    for (int i = 0; i < 20 && uartTx !== 1'b0; i++) tick();
    check("t5_frame_started", {31'b0, uartTx}, 32'd0);
    writeCmd(8'($urandom));
    repeat (17) tick();
    check("t5_queued", txStatus, mkStatus(tgl, 1'b0, 1'b0, 1'b1, 1));
    check("t5_line_low_before_reset", {31'b0, uartTx}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("t5_async_line", {31'b0, uartTx}, 32'd1);
    check("t5_async_status", txStatus, 32'h00000400);
    tgl = 1'b0;
    en  = 1'b1;
    txCommand = 32'h80000000;
    expQ.delete();
    rxQ.delete();
    repeat (3) tick();
    reset = 1'b1;
    lowSeen = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (uartTx !== 1'b1) lowSeen++;
    end
    check("t5_no_frames_after_reset", lowSeen, 0);
    check("t5_status_after_reset", txStatus, 32'h00000400);
    check("t5_rx_empty", rxQ.size(), 0);

    // 6: disable mid-frame with two bytes queued
    writeCmd(8'($urandom));
    waitAck("t6_ack1");
    writeCmd(8'($urandom));
    waitAck("t6_ack2");
    writeCmd(8'($urandom));
    waitAck("t6_ack3");
    repeat (5) tick();
    setEnable(1'b0);
    check("t6_mid_frame", txStatus, mkStatus(tgl, 1'b0, 1'b0, 1'b1, 2));
    repeat (60) tick();
    check("t6_paused", txStatus, mkStatus(tgl, 1'b0, 1'b0, 1'b0, 2));
    check("t6_line_idle", {31'b0, uartTx}, 32'd1);
    check("t6_one_frame", rxQ.size(), 1);
    setEnable(1'b1);
    drainCompare("t6");

    // 7: random bytes with random gaps
    for (int i = 0; i < 10; i++) begin
      writeCmd(8'($urandom));
      waitAck("t7_ack");
      repeat ($urandom_range(0, 30)) tick();
    end
    drainCompare("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
